inst_fetch: RTL and testbench

- Instruction-fetch stage directly upstream of the IF/ID register and decode stage. Supplies the pc/inst pair that decode consumes.
- Generates sequential fetch addresses and runs a single-outstanding req/ack handshake with instruction memory. Memory latency is variable.
- Buffers returned instructions in a small FIFO so memory latency and downstream stalls are decoupled.
- Supports a redirect (flush) from a later stage, with correct discard of any in-flight response.

---
 rtl/inst_fetch_pkg.sv | 36 +++
 rtl/inst_fetch_fifo.sv | 75 +++++++
 rtl/inst_fetch.sv | 155 +++++++++++++++
 tb/tb_inst_fetch.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_pkg
// Shared constants and types for the instruction-fetch stage.
//   RstEnable        : level of rst that holds the stage in reset
//   ZeroWord         : all-zero data/address word (NOP presented to decode)
//   InstAddrBus      : width of an instruction address
//   InstBus          : width of an instruction word
//   InstFetchPcReset : default first fetch address after reset
//   fetch_state_e    : IDLE / REQ / DRAIN fetch sequencer states
//   fetch_entry_t    : one {pc, inst} instruction-queue entry
//   word_align()     : forces the two low address bits to zero
// -----------------------------------------------------------------------------
package inst_fetch_pkg;

    localparam logic        RstEnable        = 1'b1;
    localparam int          InstAddrBus      = 32;
    localparam int          InstBus          = 32;
    localparam logic [31:0] ZeroWord         = 32'h0000_0000;
    localparam logic [31:0] InstFetchPcReset = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'b00,
        FETCH_REQ   = 2'b01,
        FETCH_DRAIN = 2'b10
    } fetch_state_e;

    typedef struct packed {
        logic [InstAddrBus-1:0] pc;
        logic [InstBus-1:0]     inst;
    } fetch_entry_t;

    function automatic logic [InstAddrBus-1:0] word_align(input logic [InstAddrBus-1:0] addr);
        return {addr[InstAddrBus-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_fifo.sv
// -----------------------------------------------------------------------------
// inst_fifo
// Small synchronous queue of {pc, inst} entries between the memory response
// and the decode stage.
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write push_data at the tail (ignored when full)
//   pop        : drop the head entry (ignored when empty)
//   clear      : empty the queue; wins over push and pop
//   push_data  : entry written on push
//   head       : current head entry, read combinationally from storage
//   full/empty : occupancy flags
//   count      : number of valid entries
// DEPTH must be a power of two so the pointers wrap on their own.
// -----------------------------------------------------------------------------
module inst_fifo
    import inst_fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  fetch_entry_t     push_data,
    output fetch_entry_t     head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; clear empties the queue in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage needs no reset: an entry is only visible once count covers it.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
// Instruction-fetch stage feeding the IF/ID register. Issues sequential
// word-aligned fetches over a single-outstanding req/ack handshake, queues
// the returned words and hands the head {pc, inst} to decode.
//   clk, rst      : clock, asynchronous active-high reset
//   stall_i       : decode cannot take the head entry this cycle
//   flush_i       : redirect; drops queued and in-flight instructions
//   flush_pc_i    : redirect target (low two bits ignored)
//   imem_req_o    : registered fetch request
//   imem_addr_o   : registered fetch address, stable until acked
//   imem_ack_i    : memory response, completes the outstanding request
//   imem_rdata_i  : instruction word returned with the ack
//   valid_o       : pc_o/inst_o carry a real instruction
//   pc_o, inst_o  : head instruction, zero (NOP) when the queue is empty
// -----------------------------------------------------------------------------
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [InstAddrBus-1:0] PC_RESET   = InstFetchPcReset,
    parameter int                     FIFO_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_i,
    input  logic                   flush_i,
    input  logic [InstAddrBus-1:0] flush_pc_i,
    output logic                   imem_req_o,
    output logic [InstAddrBus-1:0] imem_addr_o,
    input  logic                   imem_ack_i,
    input  logic [InstBus-1:0]     imem_rdata_i,
    output logic                   valid_o,
    output logic [InstAddrBus-1:0] pc_o,
    output logic [InstBus-1:0]     inst_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    fetch_state_e           state;
    fetch_state_e           state_next;
    logic [InstAddrBus-1:0] fetch_pc;
    logic [InstAddrBus-1:0] fetch_pc_next;
    logic [InstAddrBus-1:0] addr_next;
    logic                   req_next;

    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CNT_W-1:0]       fifo_count;
    logic [CNT_W:0]         occ_after;
    logic                   has_credit;
    fetch_entry_t           push_entry;
    fetch_entry_t           head_entry;

    // Only an ack to a live (non-drained) request lands in the queue; a
    // flush in the same cycle throws the word away.
    assign fifo_push  = (state == FETCH_REQ) && imem_ack_i && !flush_i;
    assign fifo_pop   = !fifo_empty && !stall_i && !flush_i;
    assign push_entry = '{pc: fetch_pc, inst: imem_rdata_i};

    // A new request may only go out if its eventual response is sure to find
    // a free slot, judged on the occupancy left after this cycle's push/pop.
    assign occ_after  = {1'b0, fifo_count} + (CNT_W+1)'(fifo_push) - (CNT_W+1)'(fifo_pop);
    assign has_credit = fifo_full ? (fifo_pop && !fifo_push)
                                  : (occ_after < (CNT_W+1)'(FIFO_DEPTH));

    inst_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_inst_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .clear     (flush_i),
        .push_data (push_entry),
        .head      (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Decode sees a NOP rather than stale storage when nothing is queued.
    assign valid_o = !fifo_empty;
    assign pc_o    = fifo_empty ? ZeroWord : head_entry.pc;
    assign inst_o  = fifo_empty ? ZeroWord : head_entry.inst;

    // State, fetch pointer and the registered request outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            state       <= FETCH_IDLE;
            fetch_pc    <= PC_RESET;
            imem_req_o  <= 1'b0;
            imem_addr_o <= ZeroWord;
        end else begin
            state       <= state_next;
            fetch_pc    <= fetch_pc_next;
            imem_req_o  <= req_next;
            imem_addr_o <= addr_next;
        end
    end

    // Next-state logic. While draining, fetch_pc already holds the redirect
    // target and imem_addr_o keeps the old address until memory answers.
    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        req_next      = imem_req_o;
        addr_next     = imem_addr_o;

        if (flush_i) begin
            fetch_pc_next = word_align(flush_pc_i);
            if ((state != FETCH_IDLE) && !imem_ack_i) begin
                state_next = FETCH_DRAIN;
            end else begin
                state_next = FETCH_REQ;
                req_next   = 1'b1;
                addr_next  = word_align(flush_pc_i);
            end
        end else begin
            case (state)
                FETCH_IDLE: begin
                    if (has_credit) begin
                        state_next = FETCH_REQ;
                        req_next   = 1'b1;
                        addr_next  = fetch_pc;
                    end
                end
                FETCH_REQ: begin
                    if (imem_ack_i) begin
                        fetch_pc_next = fetch_pc + 32'd4;
                        if (has_credit) begin
                            addr_next = fetch_pc + 32'd4;
                        end else begin
                            state_next = FETCH_IDLE;
                            req_next   = 1'b0;
                        end
                    end
                end
                FETCH_DRAIN: begin
                    if (imem_ack_i) begin
                        state_next = FETCH_REQ;
                        req_next   = 1'b1;
                        addr_next  = fetch_pc;
                    end
                end
                default: begin
                    state_next = FETCH_IDLE;
                    req_next   = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
// Self-checking bench for inst_fetch: a behavioural instruction memory with
// programmable wait states, a scoreboard of expected {pc, inst} deliveries,
// a per-cycle vector table for the stall sequence and hand-written flush,
// reset and address-wrap sequences.
// -----------------------------------------------------------------------------
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;

    always #5 clk = ~clk;

    inst_fetch #(
        .PC_RESET   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall),
        .flush_i      (flush),
        .flush_pc_i   (flush_pc),
        .imem_req_o   (req),
        .imem_addr_o  (addr),
        .imem_ack_i   (ack),
        .imem_rdata_i (rdata),
        .valid_o      (valid),
        .pc_o         (pc),
        .inst_o       (inst)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    typedef struct {
        logic        stall;
        logic        req;
        logic        chk_addr;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    logic [31:0] exp_addr;
    logic [31:0] drain_addr;
    bit          draining;
    int          latency;
    int          wait_cnt;
    bit          force_ack;
    vec_t        stall_vecs[11];

    function automatic logic [31:0] inst_for(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic compareValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One clock cycle: check this cycle's outputs against the model, let the
    // memory model decide on an ack, drive the inputs, then update the model.
    task automatic applyStimulus(input logic st, input logic fl, input logic [31:0] fpc);
        logic a;
        exp_t e;
        @(negedge clk);
        compareValue("valid_vs_queue", valid, sb.size() != 0);
        if (req) begin
            if (draining) compareValue("drain_addr", addr, drain_addr);
            else          compareValue("req_addr", addr, exp_addr);
        end
        a = 1'b0;
        if (force_ack) begin
            a = 1'b1;
        end else if (req) begin
            if (wait_cnt >= latency) begin
                a = 1'b1;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end
        ack      = a;
        rdata    = a ? inst_for(addr) : 32'h0;
        stall    = st;
        flush    = fl;
        flush_pc = fpc;
        if (valid && !st && !fl && sb.size() != 0) begin
            e = sb.pop_front();
            compareValue("deliver_pc", pc, e.pc);
            compareValue("deliver_inst", inst, e.inst);
        end
        if (fl) begin
            sb.delete();
            if (req && !a) begin
                if (!draining) drain_addr = exp_addr;
                draining = 1'b1;
            end else begin
                draining = 1'b0;
            end
            exp_addr = {fpc[31:2], 2'b00};
        end else if (a && req) begin
            if (draining) begin
                draining = 1'b0;
            end else begin
                sb.push_back('{exp_addr, inst_for(exp_addr)});
                exp_addr = exp_addr + 32'd4;
            end
        end
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("stall_row%0d", idx);
        compareValue({tag, "_req"}, req, v.req);
        if (v.chk_addr) compareValue({tag, "_addr"}, addr, v.addr);
        compareValue({tag, "_valid"}, valid, v.valid);
        compareValue({tag, "_pc"}, pc, v.pc);
        if (v.valid) compareValue({tag, "_inst"}, inst, inst_for(v.pc));
    endtask

    task automatic doReset();
        rst       = 1'b1;
        stall     = 1'b0;
        flush     = 1'b0;
        flush_pc  = 32'h0;
        ack       = 1'b0;
        rdata     = 32'h0;
        sb.delete();
        draining  = 1'b0;
        exp_addr  = 32'h0;
        wait_cnt  = 0;
        force_ack = 1'b0;
        latency   = 0;
        repeat (2) @(negedge clk);
        compareValue("rst_req", req, 1'b0);
        compareValue("rst_addr", addr, 32'h0);
        compareValue("rst_valid", valid, 1'b0);
        compareValue("rst_pc", pc, 32'h0);
        compareValue("rst_inst", inst, 32'h0);
        rst = 1'b0;
    endtask

    initial begin
        // stall, req, chk_addr, addr, valid, pc for cycles 1..11 after reset
        stall_vecs[0]  = '{1'b0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0};
        stall_vecs[1]  = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b1, 32'h0};
        stall_vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h0};
        stall_vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h0};
        stall_vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h0};
        stall_vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h0};
        stall_vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h0};
        stall_vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 32'h0};
        stall_vecs[8]  = '{1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h4};
        stall_vecs[9]  = '{1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h8};
        stall_vecs[10] = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'hC};

        // Zero-wait memory: back-to-back fetches, continuous delivery.
        doReset();
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b0, 1'b0, 32'h0);
            compareValue("zw_req", req, 1'b1);
            compareValue("zw_addr", addr, 32'(4 * (k - 1)));
            compareValue("zw_valid", valid, k >= 2);
            if (k >= 2) compareValue("zw_pc", pc, 32'(4 * (k - 2)));
        end

        // Two wait states: one fetch every third cycle, single-cycle valid.
        doReset();
        latency = 2;
        for (int k = 1; k <= 15; k++) begin
            applyStimulus(1'b0, 1'b0, 32'h0);
            compareValue("slow_valid", valid, (k >= 4) && (k % 3 == 1));
        end

        // Six-cycle stall with zero-wait memory, checked against the table.
        doReset();
        for (int i = 0; i < 11; i++) begin
            applyStimulus(stall_vecs[i].stall, 1'b0, 32'h0);
            checkOutput(stall_vecs[i], i);
        end

        // Flush while the request to 8 is outstanding, re-flush in DRAIN.
        doReset();
        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        latency = 2;
        applyStimulus(1'b0, 1'b1, 32'h0000_00F0);
        compareValue("drain_old_addr", addr, 32'h8);
        applyStimulus(1'b0, 1'b1, 32'h0000_0103);
        compareValue("drain_valid_c4", valid, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        compareValue("drain_hold_addr", addr, 32'h8);
        compareValue("drain_valid_c5", valid, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        compareValue("redirect_addr", addr, 32'h100);
        compareValue("redirect_req", req, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        compareValue("drain_valid_c8", valid, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        compareValue("redirect_valid", valid, 1'b1);
        compareValue("redirect_pc", pc, 32'h100);
        latency = 0;
        repeat (3) applyStimulus(1'b0, 1'b0, 32'h0);

        // Flush and ack in the same cycle: acked word is discarded.
        doReset();
        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'h0000_0200);
        applyStimulus(1'b0, 1'b0, 32'h0);
        compareValue("fa_valid", valid, 1'b0);
        compareValue("fa_addr", addr, 32'h200);
        compareValue("fa_no_stale", inst == inst_for(32'h4), 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        compareValue("fa_pc", pc, 32'h200);
        compareValue("fa_inst", inst, inst_for(32'h200));
        compareValue("fa_no_stale2", inst == inst_for(32'h4), 1'b0);

        // Reset mid-request with acks during and right after reset.
        doReset();
        latency = 3;
        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        #2;
        rst   = 1'b1;
        ack   = 1'b1;
        rdata = 32'hDEAD_BEEF;
        #1;
        compareValue("midrst_req", req, 1'b0);
        compareValue("midrst_addr", addr, 32'h0);
        compareValue("midrst_valid", valid, 1'b0);
        compareValue("midrst_pc", pc, 32'h0);
        compareValue("midrst_inst", inst, 32'h0);
        repeat (2) @(negedge clk);
        sb.delete();
        draining = 1'b0;
        exp_addr = 32'h0;
        wait_cnt = 0;
        latency  = 0;
        rst      = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0);
        compareValue("postrst_req", req, 1'b1);
        compareValue("postrst_addr", addr, 32'h0);
        compareValue("postrst_valid", valid, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        compareValue("postrst_pc", pc, 32'h0);
        compareValue("postrst_inst", inst, inst_for(32'h0));

        // Fetch pointer wraps from 0xFFFFFFFC to 0.
        doReset();
        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF9);
        applyStimulus(1'b0, 1'b0, 32'h0);
        compareValue("wrap_addr0", addr, 32'hFFFF_FFF8);
        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        compareValue("wrap_addr2", addr, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        compareValue("wrap_pc", pc, 32'h0);
        repeat (2) applyStimulus(1'b0, 1'b0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
